// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with glitch-free, wrap-aligned divisor updates.
// Optional `SYNC_EN adds a sync_clr input that restarts every channel in phase.
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 25000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef SYNC_EN
  input  logic              sync_clr,
`endif
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] shadow;
    logic             clk_q;
    logic             tick_q;
    logic             pend_q;
    logic             wr;
    logic             running;
    logic             wrap;

    // Out-of-range channel numbers never match, so such writes are dropped.
    assign wr      = cfg_we && (cfg_ch == CH_W'(c));
    assign running = ch_en[c] && (div_active != '0);
    assign wrap    = (count == div_active - CNT_W'(1));

    // NOTE: every register here is updated with <= so all channels see the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (!rst) begin
        count      <= '0;
        div_active <= DIV_RST;
        shadow     <= DIV_RST;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        pend_q     <= 1'b0;
      end
`ifdef SYNC_EN
      else if (sync_clr) begin
        count  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        if (wr)          div_active <= cfg_div;
        else if (pend_q) div_active <= shadow;
      end
`endif
      else begin
        tick_q <= 1'b0;
        if (wr && !running) begin
          // An idle channel has no phase to protect, so take the value at once.
          div_active <= cfg_div;
          count      <= '0;
          pend_q     <= 1'b0;
        end else begin
          if (running) begin
            if (wrap) begin
              count  <= '0;
              clk_q  <= ~clk_q;
              tick_q <= 1'b1;
              if (pend_q) begin
                div_active <= shadow;
                pend_q     <= 1'b0;
              end
            end else begin
              count <= count + CNT_W'(1);
            end
          end else if (div_active == '0) begin
            count <= '0;
          end
          // A write on the wrap edge lands after the old shadow was consumed.
          if (wr) begin
            shadow <= cfg_div;
            pend_q <= 1'b1;
          end
        end
      end
    end

    assign clk_div[c] = clk_q;
    assign tick[c]    = tick_q;
    assign pending[c] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: expected tick events are queued per
// channel at stimulus time and a negedge monitor matches them against the DUT.
module tb_clock_divider_multi;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  typedef struct {
    int   cyc;
    logic lvl;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
`ifdef SYNC_EN
  logic              sync_clr = 1'b0;
`endif
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  b0, b1;
  ev_t q0[$];
  ev_t q1[$];
  ev_t mon_e;

  clock_divider_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_en(ch_en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
`ifdef SYNC_EN
    .sync_clr(sync_clr),
`endif
    .clk_div(clk_div),
    .tick(tick),
    .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int ch, input int t, input logic lvl);
    ev_t e;
    e.cyc = t;
    e.lvl = lvl;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Issues a one-cycle write; returns on the negedge after the sampling edge.
  task automatic write_div(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = CNT_W'(d);
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  // Monitor: every tick must match the head of its channel's queue; an
  // expected event whose cycle has passed without a tick is a miss.
  always @(negedge clk) begin
    if (tick[0]) begin
      if (q0.size() == 0) check("ch0 unexpected tick", {31'd0, tick[0]}, 32'd0);
      else begin
        mon_e = q0.pop_front();
        check("ch0 tick cycle", cyc, mon_e.cyc);
        check("ch0 level at tick", {31'd0, clk_div[0]}, {31'd0, mon_e.lvl});
      end
    end else if (q0.size() != 0 && q0[0].cyc < cyc) begin
      mon_e = q0.pop_front();
      check("ch0 missed tick", {31'd0, tick[0]}, 32'd1);
    end
    if (tick[1]) begin
      if (q1.size() == 0) check("ch1 unexpected tick", {31'd0, tick[1]}, 32'd0);
      else begin
        mon_e = q1.pop_front();
        check("ch1 tick cycle", cyc, mon_e.cyc);
        check("ch1 level at tick", {31'd0, clk_div[1]}, {31'd0, mon_e.lvl});
      end
    end else if (q1.size() != 0 && q1[0].cyc < cyc) begin
      mon_e = q1.pop_front();
      check("ch1 missed tick", {31'd0, tick[1]}, 32'd1);
    end
    if (tick[2]) check("ch2 tick while disabled", {31'd0, tick[2]}, 32'd0);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset clk_div", 32'(clk_div), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    check("reset pending", 32'(pending), 32'd0);

    // Default divisor 4 on both channels: toggles every 4 cycles from release.
    b0 = cyc;
    for (int k = 1; k <= 7; k++) push(1, b0 + 4 * k, logic'(k % 2));
    for (int k = 1; k <= 3; k++) push(0, b0 + 4 * k, logic'(k % 2));
    rst   = 1'b1;
    ch_en = 3'b011;

    // ch0 mid half-period write of 2: old divisor finishes, then period 4.
    wait_to(b0 + 13);
    for (int t = 16; t <= 72; t += 2) push(0, b0 + t, logic'((t % 4) == 2));
    write_div(0, 2);
    check("ch0 pending after write", {31'd0, pending[0]}, 32'd1);
    wait_to(b0 + 16);
    check("ch0 pending cleared at wrap", {31'd0, pending[0]}, 32'd0);

    // ch1 paused with count 1 for 5 cycles, then completes its half-period.
    wait_to(b0 + 29);
    ch_en[1] = 1'b0;
    push(1, b0 + 37, 1'b0);
    push(1, b0 + 41, 1'b1);
    push(1, b0 + 45, 1'b0);
    wait_to(b0 + 32);
    check("ch1 frozen level", {31'd0, clk_div[1]}, 32'd1);
    wait_to(b0 + 34);
    ch_en[1] = 1'b1;

    // Write to a non-existent channel must change nothing.
    wait_to(b0 + 40);
    write_div(3, 1);
    check("out-of-range write pending", 32'(pending), 32'd0);

    // Write to disabled ch1 applies immediately; first tick 3 cycles after enable.
    wait_to(b0 + 46);
    ch_en[1] = 1'b0;
    wait_to(b0 + 48);
    write_div(1, 3);
    check("ch1 immediate apply pending", {31'd0, pending[1]}, 32'd0);
    check("ch1 level held on apply", {31'd0, clk_div[1]}, 32'd0);
    wait_to(b0 + 52);
    ch_en[1] = 1'b1;
    push(1, b0 + 55, 1'b1);
    push(1, b0 + 58, 1'b0);
    push(1, b0 + 61, 1'b1);
    push(1, b0 + 64, 1'b0);

    // Divisor 0 on running ch1 stops it at the next wrap.
    wait_to(b0 + 62);
    write_div(1, 0);
    check("ch1 zero pending", {31'd0, pending[1]}, 32'd1);
    wait_to(b0 + 64);
    check("ch1 zero applied", {31'd0, pending[1]}, 32'd0);

    // Pending 6, then 9 written on the exact wrap edge: 6 now, 9 next wrap.
    wait_to(b0 + 70);
    write_div(0, 6);
    push(0, b0 + 78, 1'b1);
    push(0, b0 + 87, 1'b0);
    push(0, b0 + 96, 1'b1);
    write_div(0, 9);
    check("ch0 new value pending on wrap", {31'd0, pending[0]}, 32'd1);
    wait_to(b0 + 78);
    check("ch0 second value applied", {31'd0, pending[0]}, 32'd0);
    wait_to(b0 + 90);
    check("ch1 stopped level held", {31'd0, clk_div[1]}, 32'd0);

    // Mid-run reset with clk_div high and a pending write outstanding.
    wait_to(b0 + 98);
    write_div(0, 5);
    check("ch0 pending before reset", {31'd0, pending[0]}, 32'd1);
    wait_to(b0 + 100);
    rst = 1'b0;
    @(negedge clk);
    check("mid-run reset clk_div", 32'(clk_div), 32'd0);
    check("mid-run reset pending", 32'(pending), 32'd0);
    check("mid-run reset tick", 32'(tick), 32'd0);
    @(negedge clk);
    b1 = cyc;
    rst = 1'b1;
    push(0, b1 + 4, 1'b1);
    push(1, b1 + 4, 1'b1);
`ifdef SYNC_EN
    wait_to(b1 + 5);
    write_div(0, 3);
    check("ch0 pending before sync", {31'd0, pending[0]}, 32'd1);
    cfg_we   = 1'b1;
    cfg_ch   = 2'd1;
    cfg_div  = CNT_W'(5);
    sync_clr = 1'b1;
    push(0, b1 + 10, 1'b1);
    push(0, b1 + 13, 1'b0);
    push(0, b1 + 16, 1'b1);
    push(0, b1 + 19, 1'b0);
    push(0, b1 + 22, 1'b1);
    push(1, b1 + 12, 1'b1);
    push(1, b1 + 17, 1'b0);
    push(1, b1 + 22, 1'b1);
    @(negedge clk);
    cfg_we   = 1'b0;
    sync_clr = 1'b0;
    check("sync clr clk_div", 32'(clk_div), 32'd0);
    check("sync clr pending", 32'(pending), 32'd0);
`else
    for (int k = 2; k <= 5; k++) begin
      push(0, b1 + 4 * k, logic'(k % 2));
      push(1, b1 + 4 * k, logic'(k % 2));
    end
`endif

    wait_to(b1 + 23);
    check("ch0 outstanding events", q0.size(), 32'd0);
    check("ch1 outstanding events", q1.size(), 32'd0);
    check("ch2 disabled level", {31'd0, clk_div[2]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
